// File: rtl/mips_pkg.sv
// Shared widths for the instruction-fetch path.
package mips_pkg;
  localparam int AW_DEF   = 9;
  localparam int DW_DEF   = 32;
  localparam int BUNDLE_W = DW_DEF + AW_DEF;  // {instr, pc} entry
endpackage

// File: rtl/fetch_buf.sv
// 2-entry circular FIFO of {instr, pc} bundles; flush empties it in one edge.
module fetch_buf import mips_pkg::*; #(
  parameter int W = BUNDLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head,
  output logic         valid,
  output logic [1:0]   count
);
  logic [1:0][W-1:0] ent;
  logic              rd_ptr, wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        ent[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

  assign head  = ent[rd_ptr];
  assign valid = (count != 2'd0);

  // The issue throttle upstream must never let a push reach a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && count == 2'd2));
endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch: sync-read instruction memory, in-flight tag, 2-entry output
// buffer and PC hold so no fetched word is lost while decode stalls.
module imem_fetch import mips_pkg::*; #(
  parameter int    AW        = AW_DEF,
  parameter int    DW        = DW_DEF,
  parameter string INIT_FILE = ""
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [AW-1:0] i_pc,
  input  logic          i_pc_vld,
  output logic          o_pc_stall,
  input  logic          i_flush,
  input  logic          i_ld_we,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [DW-1:0] i_ld_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_instr,
  output logic [AW-1:0] o_instr_pc
);
  localparam int BW = DW + AW;

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rd_pc;
  logic          inflight;
  logic [1:0]    count, occ;
  logic          buf_valid, pop, issue, push, byp;
  logic [BW-1:0] head;

  assign pop        = o_valid & i_ready;
  assign occ        = count + {1'b0, inflight};
  assign issue      = i_pc_vld & ~i_ld_we & ~i_flush & ((occ < 2'd2) | pop);
  assign o_pc_stall = i_pc_vld & ~issue;

  // Load and issue are mutually exclusive, so the port never sees a collision.
  always_ff @(posedge i_clk) begin
    if (i_ld_we) mem[i_ld_addr] <= i_ld_data;
    if (issue)   rd_data <= mem[i_pc];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      inflight <= 1'b0;
      rd_pc    <= '0;
    end else begin
      inflight <= issue;
      if (issue) rd_pc <= i_pc;
    end
  end

  // With the buffer empty the fresh read is shown directly (one-cycle latency);
  // if decode takes it right away it never enters the buffer.
  assign byp  = inflight & ~buf_valid;
  assign push = inflight & ~i_flush & ~(byp & i_ready);

  fetch_buf #(.W(BW)) u_buf (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .push_data ({rd_data, rd_pc}),
    .pop       (pop & buf_valid),
    .flush     (i_flush),
    .head      (head),
    .valid     (buf_valid),
    .count     (count)
  );

  assign o_valid               = buf_valid | inflight;
  assign {o_instr, o_instr_pc} = byp ? {rd_data, rd_pc} : head;
endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: stimulus queues expected {instr,pc}; a monitor
// pops and compares on every accepted beat.
module tb_imem_fetch;
  localparam int AW = 9;
  localparam int DW = 32;

  logic          i_clk = 1'b0, i_rst = 1'b0;
  logic [AW-1:0] i_pc = '0, i_ld_addr = '0;
  logic          i_pc_vld = 1'b0, i_flush = 1'b0, i_ld_we = 1'b0, i_ready = 1'b1;
  logic [DW-1:0] i_ld_data = '0;
  logic          o_pc_stall, o_valid;
  logic [DW-1:0] o_instr;
  logic [AW-1:0] o_instr_pc;

  imem_fetch #(.AW(AW), .DW(DW), .INIT_FILE("")) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pc(i_pc), .i_pc_vld(i_pc_vld),
    .o_pc_stall(o_pc_stall), .i_flush(i_flush), .i_ld_we(i_ld_we),
    .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_instr(o_instr), .o_instr_pc(o_instr_pc)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed { logic [DW-1:0] instr; logic [AW-1:0] pc; } exp_t;
  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] mdl [2**AW];
  int            pass_cnt = 0, total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic set(input logic vld, input logic [AW-1:0] pc, input logic rdy, input logic fl);
    i_pc_vld = vld; i_pc = pc; i_ready = rdy; i_flush = fl; i_ld_we = 1'b0;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_ld_we = 1'b1; i_ld_addr = a; i_ld_data = d; mdl[a] = d;
    tick();
    i_ld_we = 1'b0;
  endtask

  task automatic expect_fetch(input logic [AW-1:0] pc);
    sb.push_back({mdl[pc], pc});
  endtask

  // Four-word stream right after a load: o_valid one cycle after the first issue.
  task automatic s1_fetch(input string tag);
    for (int k = 0; k < 4; k++) begin
      set(1'b1, AW'(k), 1'b1, 1'b0);
      expect_fetch(AW'(k));
      @(negedge i_clk);
      chk({tag, "_stall"}, o_pc_stall, 0);
      chk({tag, "_valid"}, o_valid, (k != 0));
      tick();
    end
    set(1'b0, '0, 1'b1, 1'b0);
    @(negedge i_clk); chk({tag, "_drain_valid"}, o_valid, 1); tick();
    @(negedge i_clk); chk({tag, "_idle_valid"}, o_valid, 0); tick();
  endtask

  // Scoreboard monitor
  initial forever begin
    @(negedge i_clk);
    if (!i_rst && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL sb_unexpected: got pc %0h instr %0h, expected no beat", o_instr_pc, o_instr);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_instr", o_instr, mon_e.instr);
        chk("sb_pc", o_instr_pc, mon_e.pc);
      end
    end
  end

  initial begin
    for (int a = 0; a < 2**AW; a++) mdl[a] = '0;
    #1 i_rst = 1'b1;
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_instr", o_instr, 0);
    chk("rst_pc", o_instr_pc, 0);
    chk("rst_stall", o_pc_stall, 0);
    tick(); tick();
    i_rst = 1'b0;

    load(9'd4, 32'h55); load(9'd5, 32'h66); load(9'd6, 32'h77); load(9'd7, 32'h88);
    load(9'h40, 32'hCAFE_0040); load(9'd511, 32'hDEAD_01FF);
    load(9'd0, 32'h11); load(9'd1, 32'h22); load(9'd2, 32'h33); load(9'd3, 32'h44);

    // 1: basic stream
    s1_fetch("s1");

    // 2: decode stall fills the buffer, head held, no loss on resume
    set(1'b1, 9'd0, 1'b1, 1'b0); expect_fetch(9'd0);
    @(negedge i_clk); chk("s2a_stall", o_pc_stall, 0); tick();
    set(1'b1, 9'd1, 1'b1, 1'b0); expect_fetch(9'd1);
    @(negedge i_clk); chk("s2b_stall", o_pc_stall, 0); tick();
    set(1'b1, 9'd2, 1'b0, 1'b0); expect_fetch(9'd2);
    @(negedge i_clk); chk("s2c_stall", o_pc_stall, 0); chk("s2c_instr", o_instr, 32'h22); tick();
    for (int k = 0; k < 2; k++) begin
      set(1'b1, 9'd3, 1'b0, 1'b0);
      @(negedge i_clk);
      chk("s2_hold_stall", o_pc_stall, 1);
      chk("s2_hold_instr", o_instr, 32'h22);
      chk("s2_hold_pc", o_instr_pc, 1);
      tick();
    end
    set(1'b1, 9'd3, 1'b1, 1'b0); expect_fetch(9'd3);
    @(negedge i_clk); chk("s2_resume_stall", o_pc_stall, 0); tick();
    set(1'b0, '0, 1'b1, 1'b0); tick(); tick();
    @(negedge i_clk); chk("s2_idle_valid", o_valid, 0); tick();

    // 3a: flush with one buffered and one in-flight word, then redirect to 0x40
    set(1'b1, 9'd4, 1'b0, 1'b0); tick();
    set(1'b1, 9'd5, 1'b0, 1'b0); tick();
    set(1'b1, 9'd6, 1'b0, 1'b1);
    @(negedge i_clk); chk("s3_flush_stall", o_pc_stall, 1); chk("s3_flush_valid", o_valid, 1); tick();
    set(1'b1, 9'h40, 1'b1, 1'b0); expect_fetch(9'h40);
    @(negedge i_clk); chk("s3_post_valid", o_valid, 0); chk("s3_redir_stall", o_pc_stall, 0); tick();
    set(1'b0, '0, 1'b1, 1'b0);
    @(negedge i_clk); chk("s3_redir_valid", o_valid, 1); tick();
    @(negedge i_clk); chk("s3_idle_valid", o_valid, 0); tick();

    // 3b: flush with a full buffer; the head popped in the flush cycle still counts
    set(1'b1, 9'd6, 1'b0, 1'b0); tick();
    set(1'b1, 9'd7, 1'b0, 1'b0); tick();
    set(1'b0, '0, 1'b0, 1'b0); tick(); tick();
    set(1'b1, 9'd8, 1'b1, 1'b1); expect_fetch(9'd6);
    @(negedge i_clk); chk("s3b_flush_stall", o_pc_stall, 1); tick();
    set(1'b0, '0, 1'b1, 1'b0);
    @(negedge i_clk); chk("s3b_post_valid", o_valid, 0); tick();

    // 4: load while the PC requests: stalled, no issue, then new data fetched
    for (int k = 0; k < 2; k++) begin
      set(1'b1, 9'h20, 1'b1, 1'b0);
      i_ld_we = 1'b1; i_ld_addr = AW'(9'h20 + k); i_ld_data = 32'h2020_2020 + 32'(k) * 32'h0101_0101;
      mdl[i_ld_addr] = i_ld_data;
      @(negedge i_clk); chk("s4_ld_stall", o_pc_stall, 1); tick();
    end
    set(1'b0, '0, 1'b1, 1'b0);
    @(negedge i_clk); chk("s4_noissue_valid", o_valid, 0); tick();
    set(1'b1, 9'h20, 1'b1, 1'b0); expect_fetch(9'h20); tick();
    set(1'b1, 9'h21, 1'b1, 1'b0); expect_fetch(9'h21); tick();
    set(1'b0, '0, 1'b1, 1'b0); tick(); tick();

    // 5: PC wrap
    set(1'b1, 9'd511, 1'b1, 1'b0); expect_fetch(9'd511);
    @(negedge i_clk); chk("s5_stall511", o_pc_stall, 0); tick();
    set(1'b1, 9'd0, 1'b1, 1'b0); expect_fetch(9'd0);
    @(negedge i_clk); chk("s5_stall0", o_pc_stall, 0); tick();
    set(1'b0, '0, 1'b1, 1'b0); tick(); tick();

    // 6: async reset between edges mid-stream
    set(1'b1, 9'd0, 1'b1, 1'b0); expect_fetch(9'd0); tick();
    set(1'b1, 9'd1, 1'b1, 1'b0); tick();
    set(1'b1, 9'd2, 1'b1, 1'b0);
    #2 i_rst = 1'b1;
    #1;
    chk("s6_rst_valid", o_valid, 0);
    chk("s6_rst_instr", o_instr, 0);
    chk("s6_rst_pc", o_instr_pc, 0);
    set(1'b0, '0, 1'b1, 1'b0);
    tick(); tick();
    i_rst = 1'b0;
    s1_fetch("s6");

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
